// File: rtl/mult_div_ctrl.sv
// Multicycle MIPS-style mult/div sequencer: shift-add multiply / restoring divide on one shared adder.
// Optional build macro MULT_DIV_UNSIGNED_EN lets is_unsigned select multu/divu.
module mult_div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_FIX, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, q_q, q_d, m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic             is_div_q, is_div_d, neg_hi_q, neg_hi_d, neg_lo_q, neg_lo_d, dz_q, dz_d;

  logic uns;
`ifdef MULT_DIV_UNSIGNED_EN
  assign uns = is_unsigned;
`else
  logic unused_is_unsigned;
  assign uns = 1'b0;
  assign unused_is_unsigned = is_unsigned;
`endif

  logic             sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign sa    = a[WIDTH-1] & ~uns;
  assign sb    = b[WIDTH-1] & ~uns;
  assign mag_a = sa ? -a : a;
  assign mag_b = sb ? -b : b;

  // One adder: adds the multiplicand in MULT, subtracts the divisor (borrow in MSB) in DIV.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] add_a, add_b, sum;
  logic             add_cin;
  assign rem_sh = {acc_q, q_q[WIDTH-1]};

  always_comb begin
    add_a   = {2'b00, acc_q};
    add_b   = {2'b00, (q_q[0] ? m_q : {WIDTH{1'b0}})};
    add_cin = 1'b0;
    if (state_q == S_DIV) begin
      add_a   = {1'b0, rem_sh};
      add_b   = ~{2'b00, m_q};
      add_cin = 1'b1;
    end
    sum = add_a + add_b + {{(WIDTH+1){1'b0}}, add_cin};
  end

  logic [2*WIDTH-1:0] prod, prod_neg;
  assign prod     = {acc_q, q_q};
  assign prod_neg = -prod;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    q_d      = q_q;
    m_d      = m_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_hi_d = neg_hi_q;
    neg_lo_d = neg_lo_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: if (start_mult || start_div) begin
        cnt_d = CW'(WIDTH-1);
        acc_d = '0;
        dz_d  = 1'b0;
        if (start_mult) begin
          is_div_d = 1'b0;
          m_d      = mag_a;
          q_d      = mag_b;
          neg_hi_d = sa ^ sb;
          neg_lo_d = sa ^ sb;
          state_d  = S_MULT;
        end else begin
          is_div_d = 1'b1;
          m_d      = mag_b;
          q_d      = mag_a;
          neg_hi_d = sa;
          neg_lo_d = sa ^ sb;
          if (b == '0) begin
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_DIV;
          end
        end
      end
      S_MULT: begin
        acc_d = sum[WIDTH:1];
        q_d   = {sum[0], q_q[WIDTH-1:1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_DIV: begin
        if (!sum[WIDTH+1]) begin
          acc_d = sum[WIDTH-1:0];
          q_d   = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rem_sh[WIDTH-1:0];
          q_d   = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = neg_hi_q ? -acc_q : acc_q;
          lo_d = neg_lo_q ? -q_q : q_q;
        end else begin
          {hi_d, lo_d} = neg_hi_q ? prod_neg : prod;
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_hi_q <= 1'b0;
      neg_lo_q <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      m_q      <= m_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_hi_q <= neg_hi_d;
      neg_lo_q <= neg_lo_d;
      dz_q     <= dz_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign div_zero = dz_q;
endmodule

// File: tb/tb_mult_div_ctrl.sv
// Self-checking bench for mult_div_ctrl: directed vector table, corner sequences, random ops vs arithmetic model.
module tb_mult_div_ctrl;
  logic        clock = 1'b0;
  logic        reset, start_mult, start_div, is_unsigned;
  logic [31:0] a, b, hi, lo;
  logic        busy, done, div_zero;

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl_hi = '0, mdl_lo = '0;

  mult_div_ctrl #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .is_unsigned(is_unsigned), .a(a), .b(b), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          m, d, u;
    logic [31:0] a, b, hi, lo;
    bit          dz;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on sign/zero-extended operands.
  task automatic model(input bit m, input bit u, input logic [31:0] aa, input logic [31:0] bb,
                       output logic [31:0] h, output logic [31:0] l, output bit dz, output int lat);
    bit eff_u;
    logic signed [63:0] pa, pb, r;
`ifdef MULT_DIV_UNSIGNED_EN
    eff_u = u;
`else
    eff_u = 1'b0;
    if (u) eff_u = 1'b0;
`endif
    pa = eff_u ? {32'b0, aa} : {{32{aa[31]}}, aa};
    pb = eff_u ? {32'b0, bb} : {{32{bb[31]}}, bb};
    dz = 1'b0;
    lat = 34;
    if (m) begin
      r = pa * pb;
      mdl_hi = r[63:32];
      mdl_lo = r[31:0];
    end else if (bb == 32'd0) begin
      dz = 1'b1;
      lat = 1;
    end else begin
      r = pa / pb;
      mdl_lo = r[31:0];
      r = pa % pb;
      mdl_hi = r[31:0];
    end
    h = mdl_hi;
    l = mdl_lo;
  endtask

  task automatic run_op(input bit m, input bit d, input bit u, input logic [31:0] aa, input logic [31:0] bb,
                        output int lat, output int ndone, output int nbusy,
                        output logic [31:0] h, output logic [31:0] l, output bit dz);
    @(negedge clock);
    start_mult = m; start_div = d; is_unsigned = u; a = aa; b = bb;
    @(posedge clock);
    #1 start_mult = 1'b0; start_div = 1'b0;
    lat = 0; ndone = 0; nbusy = 0; h = 'x; l = 'x; dz = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clock);
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (lat == 0) begin lat = n; h = hi; l = lo; dz = div_zero; end
      end
      if (lat != 0 && n >= lat + 3) break;
    end
  endtask

  task automatic check_op(input string tag, input vec_t v);
    int lat, nd, nb;
    logic [31:0] h, l;
    bit dz;
    run_op(v.m, v.d, v.u, v.a, v.b, lat, nd, nb, h, l, dz);
    chk({tag, " hi"}, 64'(h), 64'(v.hi));
    chk({tag, " lo"}, 64'(l), 64'(v.lo));
    chk({tag, " div_zero"}, 64'(dz), 64'(v.dz));
    chk({tag, " latency"}, 64'(lat), 64'(v.lat));
    chk({tag, " done pulses"}, 64'(nd), 64'd1);
    chk({tag, " busy cycles"}, 64'(nb), 64'(v.lat));
  endtask

  initial begin
    vec_t vt[10];
    vec_t rv;
    int nd, nb, lat;
    logic [31:0] h, l;
    bit dz;

    vt[0] = '{1,0,0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 0, 34};
    vt[1] = '{0,1,0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0, 34};
    vt[2] = '{0,1,0, 32'd95,       32'd10,       32'd5,        32'd9,        0, 34};
    vt[3] = '{0,1,0, 32'd10,       32'd0,        32'd5,        32'd9,        1, 1};
    vt[4] = '{0,1,0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 0, 34};
    vt[5] = '{1,0,0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 0, 34};
    vt[6] = '{1,1,0, 32'd6,        32'd3,        32'd0,        32'd18,       0, 34};
    vt[7] = '{0,1,0, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 0, 34};
`ifdef MULT_DIV_UNSIGNED_EN
    vt[8] = '{1,0,1, 32'hFFFFFFFF, 32'd2,        32'd1,        32'hFFFFFFFE, 0, 34};
    vt[9] = '{0,1,1, 32'hFFFFFFFF, 32'd2,        32'd1,        32'h7FFFFFFF, 0, 34};
`else
    vt[8] = '{1,0,1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 0, 34};
    vt[9] = '{0,1,1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'd0,        0, 34};
`endif

    reset = 1'b1; start_mult = 1'b0; start_div = 1'b0; is_unsigned = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset div_zero", 64'(div_zero), 64'd0);

    for (int i = 0; i < 10; i++) begin
      check_op($sformatf("vec%0d", i), vt[i]);
      mdl_hi = vt[i].hi;
      mdl_lo = vt[i].lo;
    end

    // Start pulsed while busy must be dropped.
    @(negedge clock);
    start_mult = 1'b1; a = 32'd3; b = 32'd4;
    @(posedge clock);
    #1 start_mult = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    start_div = 1'b1; a = 32'd100; b = 32'd7;
    @(posedge clock);
    #1 start_div = 1'b0;
    nd = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clock);
      if (done) begin nd++; h = hi; l = lo; end
    end
    chk("busy-start done pulses", 64'(nd), 64'd1);
    chk("busy-start lo", 64'(l), 64'd12);
    chk("busy-start hi", 64'(h), 64'd0);
    mdl_hi = 32'd0; mdl_lo = 32'd12;

    // Reset mid-operation aborts with no done pulse.
    @(negedge clock);
    start_mult = 1'b1; a = 32'd123; b = 32'd456;
    @(posedge clock);
    #1 start_mult = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort hi", 64'(hi), 64'd0);
    chk("abort lo", 64'(lo), 64'd0);
    nd = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (done) nd++;
    end
    chk("abort done pulses", 64'(nd), 64'd0);
    mdl_hi = '0; mdl_lo = '0;

    for (int i = 0; i < 30; i++) begin
      rv.m = $urandom_range(0, 1);
      rv.d = ~rv.m;
      rv.u = $urandom_range(0, 1);
      rv.a = $urandom;
      rv.b = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
      if ($urandom_range(0, 3) == 0) rv.a = 32'($urandom_range(0, 1000));
      model(rv.m, rv.u, rv.a, rv.b, rv.hi, rv.lo, dz, lat);
      rv.dz = dz;
      rv.lat = lat;
      check_op($sformatf("rand%0d", i), rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
